// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide with architectural HI/LO registers.
// Ports: clk, rst (sync, active-high); Start/Op/OperandA/OperandB launch MULT/MULTU/DIV/DIVU;
// HiWrite/LoWrite/MoveData implement MTHI/MTLO in IDLE; Busy/Done handshake;
// Hi/Lo architectural results; DivByZero sticky flag for the last divide.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] MoveData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivByZero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic is_div, dbz, neg_q, neg_r;
  logic [5:0] cnt;
  logic [31:0] m;
  logic [63:0] acc;
  logic a_neg, b_neg, zero_div, accept;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_t;
  logic [31:0] div_d, q, r;
  logic ge;
  logic [63:0] step, prod;
  logic [31:0] res_hi, res_lo;
  assign a_neg = ~Op[0] & OperandA[31];
  assign b_neg = ~Op[0] & OperandB[31];
  assign a_abs = a_neg ? -OperandA : OperandA;
  assign b_abs = b_neg ? -OperandB : OperandB;
  assign zero_div = Op[1] && OperandB == 32'd0;
  assign accept = state == IDLE && Start;
  assign Busy = state != IDLE;
  // Multiply: acc = {partial high, multiplier bits still to consume}; shift right each step.
  // Divide: acc = {remainder, dividend bits still to consume}; quotient bits enter at the bottom.
  // m holds the multiplicand or the divisor magnitude.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    div_t = {acc[63:32], acc[31]};
    ge = div_t >= {1'b0, m};
    div_d = div_t[31:0] - m;
    step = is_div ? {ge ? div_d : div_t[31:0], acc[30:0], ge} : {mul_sum, acc[31:1]};
    prod = neg_q ? -acc : acc;
    q = neg_q ? -acc[31:0] : acc[31:0];
    r = neg_r ? -acc[63:32] : acc[63:32];
    res_hi = dbz ? acc[63:32] : is_div ? r : prod[63:32];
    res_lo = dbz ? acc[31:0] : is_div ? q : prod[31:0];
    state_n = state == IDLE ? (Start ? (zero_div ? FIX : RUN) : IDLE) :
              state == RUN  ? (cnt == 6'd31 ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      Done <= 1'b0;
      Hi <= '0;
      Lo <= '0;
      DivByZero <= 1'b0;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      is_div <= 1'b0;
      dbz <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      Done <= state == FIX;
      if (state == IDLE && HiWrite) Hi <= MoveData;
      if (state == IDLE && LoWrite) Lo <= MoveData;
      if (accept) begin
        is_div <= Op[1];
        dbz <= zero_div;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt <= '0;
        DivByZero <= 1'b0;
        m <= Op[1] ? b_abs : a_abs;
        // A zero-divisor divide skips RUN, so its final Hi/Lo are parked in acc here.
        acc <= zero_div ? {OperandA, 32'hFFFF_FFFF} : {32'd0, Op[1] ? a_abs : b_abs};
      end
      if (state == RUN) begin
        acc <= step;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX) begin
        Hi <= res_hi;
        Lo <= res_lo;
        DivByZero <= dbz;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  logic clk = 0, rst = 1, Start = 0, HiWrite = 0, LoWrite = 0;
  logic [1:0] Op = 0;
  logic [31:0] OperandA = 0, OperandB = 0, MoveData = 0;
  logic Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;
  int checks = 0, errors = 0;
  int cyc, busy_n;
  logic done_seen;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .MoveData(MoveData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; Start is sampled at the following posedge (E0), returns at the negedge after E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1; Op = op; OperandA = a; OperandB = b;
    @(negedge clk);
    Start = 0; HiWrite = 0; LoWrite = 0;
  endtask

  // Counts posedges until Done is seen, and the negedge samples with Busy high (including the first).
  task automatic wait_done(output int c, output int bn);
    c = 0;
    bn = int'(Busy);
    while (!Done && c < 100) begin
      @(negedge clk);
      c++;
      bn += int'(Busy);
    end
    if (!Done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    issue(op, a, b);
    wait_done(cyc, busy_n);
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_hi"}, Hi, eh);
    check({tag, "_lo"}, Lo, el);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_dbz", DivByZero, 0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33);
    check("multu_busy_cycles", busy_n, 33);
    @(negedge clk);
    check("done_one_cycle", Done, 0);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    check("dbz_set", DivByZero, 1);

    HiWrite = 1; MoveData = 32'h5555;
    issue(2'b01, 32'd2, 32'd3);
    check("mthi_at_start", Hi, 32'h5555);
    check("dbz_cleared", DivByZero, 0);
    wait_done(cyc, busy_n);
    check("multu_small_lat", cyc, 33);
    check("multu_small_lo", Lo, 6);
    check("multu_small_hi", Hi, 0);

    HiWrite = 1; MoveData = 32'h1234;
    @(negedge clk);
    HiWrite = 0;
    check("mthi_hi", Hi, 32'h1234);
    check("mthi_lo", Lo, 6);
    HiWrite = 1; LoWrite = 1; MoveData = 32'hABCD;
    @(negedge clk);
    HiWrite = 0; LoWrite = 0;
    check("mthilo_hi", Hi, 32'hABCD);
    check("mthilo_lo", Lo, 32'hABCD);

    issue(2'b01, 32'h1_0000, 32'h1_0000);
    repeat (3) @(negedge clk);
    HiWrite = 1; MoveData = 32'hDEAD; Start = 1; Op = 2'b11; OperandA = 32'd9; OperandB = 32'd0;
    @(negedge clk);
    HiWrite = 0; Start = 0;
    check("busy_ignore_mthi", Hi, 32'hABCD);
    wait_done(cyc, busy_n);
    check("busy_ignore_lat", cyc, 29);
    check("busy_ignore_hi", Hi, 32'h1);
    check("busy_ignore_lo", Lo, 32'h0);
    check("busy_ignore_dbz", DivByZero, 0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_hi", Hi, 0);
    check("midrst_lo", Lo, 0);
    check("midrst_dbz", DivByZero, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      done_seen |= Done;
    end
    check("midrst_no_done", done_seen, 0);
    run_op("post_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
